// File: rtl/disp_source_sel.sv
// disp_source_sel: chooses the 16-bit half of a CPU debug word that the
// seven-segment scanner shows. Three debounced push-buttons step the page,
// step the register index and toggle a snapshot freeze.
module disp_source_sel #(
    parameter int unsigned DEB_CYCLES = 250000,
    parameter int unsigned CNT_W      = 18
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        btn_page,
    input  logic        btn_reg,
    input  logic        btn_frz,
    input  logic [31:0] pc,
    input  logic [31:0] instr,
    input  logic [31:0] reg_data,
    output logic [4:0]  dbg_addr,
    output logic [15:0] disp_num,
    output logic [2:0]  page,
    output logic        frozen
);

    localparam logic ST_LIVE = 1'b0;
    localparam logic ST_HOLD = 1'b1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    // Button lanes: bit 0 = page, bit 1 = reg, bit 2 = freeze
    logic [2:0]       btn_raw;
    logic [2:0]       sync_a;
    logic [2:0]       sync_b;
    logic [2:0]       stable;
    logic [2:0]       press;
    logic [CNT_W-1:0] cnt [3];

    logic        page_step;
    logic        reg_step;
    logic        frz_step;
    logic        frz_state;
    logic        recap;
    logic [31:0] snap_pc;
    logic [31:0] snap_instr;
    logic [31:0] snap_reg;
    logic [31:0] src_pc;
    logic [31:0] src_instr;
    logic [31:0] src_reg;
    logic [15:0] disp_d;

    assign btn_raw = {btn_frz, btn_reg, btn_page};

    // Two-flop synchronizers for the raw button levels
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_a <= '0;
            sync_b <= '0;
        end else begin
            sync_a <= btn_raw;
            sync_b <= sync_a;
        end
    end

    // Debounce: a differing level must persist DEB_CYCLES cycles to be accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable <= '0;
            for (int i = 0; i < 3; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (sync_b[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    stable[i] <= sync_b[i];
                    cnt[i]    <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // Press pulse on the cycle the stable level is about to rise
    always_comb begin
        press = '0;
        for (int i = 0; i < 3; i++) begin
            press[i] = sync_b[i] & ~stable[i] & (cnt[i] == CNT_LAST);
        end
    end

    assign page_step = press[0];
    assign reg_step  = press[1];
    assign frz_step  = press[2];

    // Page walks 0..5 and wraps; register index wraps mod 32
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            page     <= '0;
            dbg_addr <= '0;
        end else begin
            if (page_step) begin
                page <= (page == 3'd5) ? 3'd0 : page + 3'd1;
            end
            if (reg_step) begin
                dbg_addr <= dbg_addr + 5'd1;
            end
        end
    end

    // Freeze FSM and snapshot capture; reg_data recaptured one cycle after a
    // register step so the combinational read port has settled on the new index
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frz_state  <= ST_LIVE;
            recap      <= 1'b0;
            snap_pc    <= '0;
            snap_instr <= '0;
            snap_reg   <= '0;
        end else begin
            recap <= reg_step & (frz_state == ST_HOLD);
            if (frz_step) begin
                if (frz_state == ST_LIVE) begin
                    frz_state  <= ST_HOLD;
                    snap_pc    <= pc;
                    snap_instr <= instr;
                    snap_reg   <= reg_data;
                end else begin
                    frz_state <= ST_LIVE;
                end
            end else if (recap && (frz_state == ST_HOLD)) begin
                snap_reg <= reg_data;
            end
        end
    end

    assign frozen = (frz_state == ST_HOLD);

    // Source select and page map
    always_comb begin
        src_pc    = frozen ? snap_pc    : pc;
        src_instr = frozen ? snap_instr : instr;
        src_reg   = frozen ? snap_reg   : reg_data;
        disp_d    = 16'h0000;
        case (page)
            3'd0:    disp_d = src_pc[15:0];
            3'd1:    disp_d = src_pc[31:16];
            3'd2:    disp_d = src_instr[15:0];
            3'd3:    disp_d = src_instr[31:16];
            3'd4:    disp_d = src_reg[15:0];
            3'd5:    disp_d = src_reg[31:16];
            default: disp_d = 16'h0000;
        endcase
    end

    // Registered display word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp_num <= '0;
        end else begin
            disp_num <= disp_d;
        end
    end

endmodule

// File: tb/tb_disp_source_sel.sv
// tb_disp_source_sel: directed and randomized button sequences checked
// against a page/register/snapshot model of the display selector.
module tb_disp_source_sel;

    localparam int DEB = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        btn_page = 1'b0;
    logic        btn_reg = 1'b0;
    logic        btn_frz = 1'b0;
    logic [31:0] pc = '0;
    logic [31:0] instr = '0;
    logic [31:0] reg_data;
    logic [4:0]  dbg_addr;
    logic [15:0] disp_num;
    logic [2:0]  page;
    logic        frozen;

    logic [31:0] regfile [32];

    int compares = 0;
    int fails = 0;

    // Model state
    int          m_page = 0;
    int          m_addr = 0;
    bit          m_frozen = 1'b0;
    logic [31:0] s_pc = '0;
    logic [31:0] s_instr = '0;
    logic [31:0] s_reg = '0;

    assign reg_data = regfile[dbg_addr];

    disp_source_sel #(
        .DEB_CYCLES(DEB),
        .CNT_W     (3)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_page(btn_page),
        .btn_reg (btn_reg),
        .btn_frz (btn_frz),
        .pc      (pc),
        .instr   (instr),
        .reg_data(reg_data),
        .dbg_addr(dbg_addr),
        .disp_num(disp_num),
        .page    (page),
        .frozen  (frozen)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no finish, required finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compares++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %h required %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] exp_disp();
        logic [31:0] w;
        int sel;
        sel = m_page / 2;
        if (sel == 0)      w = m_frozen ? s_pc : pc;
        else if (sel == 1) w = m_frozen ? s_instr : instr;
        else               w = m_frozen ? s_reg : regfile[m_addr];
        return 16'(w >> (16 * (m_page % 2)));
    endfunction

    // Hold the selected buttons for 'hold' cycles, release, let things settle,
    // then apply the accepted presses to the model
    task automatic press(input logic [2:0] which, input int hold);
        bit was_frozen;
        {btn_frz, btn_reg, btn_page} = which;
        repeat (hold) tick();
        {btn_frz, btn_reg, btn_page} = 3'b000;
        repeat (DEB + 3) tick();
        if (hold >= DEB) begin
            was_frozen = m_frozen;
            if (which[2]) begin
                if (!m_frozen) begin
                    s_pc    = pc;
                    s_instr = instr;
                    s_reg   = regfile[m_addr];
                end
                m_frozen = !m_frozen;
            end
            if (which[0]) m_page = (m_page + 1) % 6;
            if (which[1]) begin
                m_addr = (m_addr + 1) % 32;
                if (was_frozen && m_frozen) s_reg = regfile[m_addr];
            end
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, "_page"}, 32'(page), 32'(m_page));
        check({tag, "_addr"}, 32'(dbg_addr), 32'(m_addr));
        check({tag, "_frozen"}, 32'(frozen), 32'(m_frozen));
        check({tag, "_disp"}, 32'(disp_num), 32'(exp_disp()));
    endtask

    initial begin
        logic [15:0] walk [6];
        int first;
        logic [2:0] sel;

        walk[0] = 16'hDEAD; walk[1] = 16'h0005; walk[2] = 16'h2002;
        walk[3] = 16'hF00D; walk[4] = 16'hCAFE; walk[5] = 16'hBEEF;
        for (int i = 0; i < 32; i++) regfile[i] = $urandom;
        pc    = 32'h0040_1234;
        instr = $urandom;

        // Reset state and release
        repeat (2) tick();
        check("rst_disp", 32'(disp_num), 32'h0);
        check("rst_page", 32'(page), 32'h0);
        check("rst_addr", 32'(dbg_addr), 32'h0);
        check("rst_frozen", 32'(frozen), 32'h0);
        rst_n = 1'b1;
        repeat (2) tick();
        check("rel_disp", 32'(disp_num), 32'h1234);

        // Short glitch is rejected
        press(3'b001, DEB - 1);
        check("glitch_page", 32'(page), 32'h0);

        // Long hold: exactly one step, on the 6th edge after the rising input
        btn_page = 1'b1;
        first = 0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (first == 0 && page != 3'd0) first = k;
        end
        btn_page = 1'b0;
        repeat (10) tick();
        check("deb_latency", 32'(first), 32'd6);
        check("deb_once", 32'(page), 32'd1);
        m_page = 1;

        // Page walk and wrap
        pc    = 32'hDEAD_BEEF;
        instr = 32'h2002_0005;
        regfile[m_addr] = 32'hCAFE_F00D;
        for (int i = 0; i < 6 && m_page != 0; i++) press(3'b001, DEB + 1);
        check("walk_start", 32'(disp_num), 32'h0000_BEEF);
        for (int i = 0; i < 6; i++) begin
            press(3'b001, DEB + int'($urandom_range(0, 3)));
            check("walk_disp", 32'(disp_num), 32'(walk[i]));
            check("walk_range", 32'(page < 3'd6), 32'd1);
            check("walk_page", 32'(page), 32'(m_page));
        end

        // Register wrap
        for (int i = 0; i < 33; i++) begin
            press(3'b010, DEB + int'($urandom_range(0, 3)));
            if (i == 31) check("reg_wrap0", 32'(dbg_addr), 32'd0);
        end
        check("reg_wrap1", 32'(dbg_addr), 32'd1);
        check("reg_model", 32'(dbg_addr), 32'(m_addr));

        // Freeze: snapshot held while live pc moves
        pc = 32'h0000_0100;
        press(3'b100, DEB + 1);
        pc = 32'h0000_0200;
        repeat (3) tick();
        check("frz_disp", 32'(disp_num), 32'h0100);
        check("frz_flag", 32'(frozen), 32'd1);

        // Register step in HOLD recaptures reg_data at the new index
        repeat (4) press(3'b001, DEB);
        regfile[m_addr] = $urandom;
        repeat (2) tick();
        check_all("hold_live_reg");
        regfile[(m_addr + 1) % 32] = $urandom;
        press(3'b010, DEB + 2);
        check_all("hold_recap");
        repeat (2) press(3'b001, DEB);
        check("hold_pc", 32'(disp_num), 32'h0100);

        // Unfreeze: live data appears one cycle after the pulse
        btn_frz = 1'b1;
        first = 0;
        for (int k = 1; k <= 20 && first == 0; k++) begin
            tick();
            if (!frozen) first = k;
        end
        check("unfrz_seen", 32'(first != 0), 32'd1);
        check("unfrz_lag", 32'(disp_num), 32'h0100);
        tick();
        check("unfrz_disp", 32'(disp_num), 32'h0200);
        btn_frz = 1'b0;
        repeat (DEB + 3) tick();
        m_frozen = 1'b0;

        // Simultaneous freeze entry and page step (page 1 -> 2)
        press(3'b001, DEB);
        instr = $urandom;
        {btn_frz, btn_page} = 2'b11;
        first = 0;
        for (int k = 1; k <= 20 && first == 0; k++) begin
            tick();
            if (page != 3'd1) first = k;
        end
        check("sim_frozen", 32'(frozen), 32'd1);
        check("sim_page", 32'(page), 32'd2);
        tick();
        check("sim_disp", 32'(disp_num), 32'(instr[15:0]));
        {btn_frz, btn_page} = 2'b00;
        repeat (DEB + 3) tick();
        m_frozen = 1'b1;
        m_page   = 2;
        s_pc     = pc;
        s_instr  = instr;
        s_reg    = regfile[m_addr];
        instr = $urandom;
        repeat (2) tick();
        check_all("sim_hold");
        // Simultaneous freeze exit and page step: live data on the new page
        press(3'b101, DEB + 1);
        check_all("sim_exit");

        // Randomized single-button sequences
        for (int i = 0; i < 24; i++) begin
            case ($urandom_range(0, 2))
                0:       sel = 3'b001;
                1:       sel = 3'b010;
                default: sel = 3'b100;
            endcase
            pc    = $urandom;
            instr = $urandom;
            regfile[$urandom_range(0, 31)] = $urandom;
            press(sel, int'($urandom_range(1, DEB + 3)));
            check_all("rand");
        end

        // Reset while frozen with a button held
        if (!m_frozen) press(3'b100, DEB);
        btn_page = 1'b1;
        tick();
        rst_n = 1'b0;
        #2;
        check("mrst_disp", 32'(disp_num), 32'h0);
        check("mrst_page", 32'(page), 32'h0);
        check("mrst_addr", 32'(dbg_addr), 32'h0);
        check("mrst_frozen", 32'(frozen), 32'h0);
        m_page   = 0;
        m_addr   = 0;
        m_frozen = 1'b0;
        tick();
        rst_n = 1'b1;
        first = 0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (first == 0 && page != 3'd0) first = k;
        end
        check("mrst_redeb", 32'(first), 32'd6);
        btn_page = 1'b0;
        repeat (DEB + 3) tick();
        m_page = 1;
        check_all("mrst_after");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
        $finish;
    end

endmodule
